memory_control: RTL and testbench

- Responder end of the CPU memory request protocol.
- Accepts instruction-fetch and data read/write requests from the datapath request logic (iREN, dREN, dWEN) and serialises them onto the single-port RAM.
- Returns one-cycle ihit/dhit strobes with load data.
- Sits between the CPU request logic and the RAM model/bus; data requests have priority over instruction fetches.

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/memory_control_if.sv | 25 ++
 rtl/memctl_watchdog.sv | 29 ++
 rtl/memory_control.sv | 118 +++++++++++
 tb/tb_memory_control.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-path types: word, RAM handshake state, controller FSM state, error word.
// Pure declarations, no latency or backpressure of its own.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [2:0] {IDLE, IFETCH, DREAD, DWRITE, DONE} memctl_state_t;

  localparam word_t ERR_WORD_DEFAULT = 32'hBAD1BAD1;

  function automatic logic is_access(input memctl_state_t s);
    return (s == IFETCH) || (s == DREAD) || (s == DWRITE);
  endfunction

endpackage

// File: rtl/memory_control_if.sv
// CPU request / RAM bus bundle; slave = memory_control, master = CPU request logic plus RAM.
// Requests are level-held until the matching hit; the RAM paces each access via ramstate.
interface memory_control_if;
  import cpu_types_pkg::*;

  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      ihit, dhit;
  word_t     iload, dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  logic      memerr;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

endinterface

// File: rtl/memctl_watchdog.sv
// Access wait counter: clears while clr, counts while en, saturates at TIMEOUT_CYCLES.
// expired is combinational from the count; no backpressure.
module memctl_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(TIMEOUT_CYCLES));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/memory_control.sv
// Serialises iREN/dREN/dWEN onto one RAM port, data first; hit 2+N cycles after sampling, N = RAM wait cycles.
// Requests wait in IDLE until accepted; MEMCTL_TIMEOUT_EN adds a watchdog, ERR_WORD loads and sticky memerr.
module memory_control
  import cpu_types_pkg::*;
#(
`ifdef MEMCTL_TIMEOUT_EN
  parameter int    TIMEOUT_CYCLES = 64,
`endif
  parameter word_t ERR_WORD = ERR_WORD_DEFAULT
) (
  input  logic              CLK,
  input  logic              nRST,
  memory_control_if.slave   mif
);

  memctl_state_t state, state_nxt, kind;
  word_t         cap_addr, cap_store, iload_q, dload_q, load_val;
  logic          in_access, abort;

  assign in_access = is_access(state);

`ifdef MEMCTL_TIMEOUT_EN
  logic expired, memerr_q;

  memctl_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .CLK     (CLK),
    .nRST    (nRST),
    .clr     (!in_access),
    .en      (in_access),
    .expired (expired)
  );

  // A real ACCESS in the same cycle always wins over an abort.
  assign abort = in_access && (mif.ramstate != ACCESS)
               && ((mif.ramstate == ERROR) || expired);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      memerr_q <= 1'b0;
    end else if (abort) begin
      memerr_q <= 1'b1;
    end
  end

  assign mif.memerr = memerr_q;
`else
  assign abort      = 1'b0;
  assign mif.memerr = 1'b0;
`endif

  assign load_val = abort ? ERR_WORD : mif.ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mif.dWEN)      state_nxt = DWRITE;
        else if (mif.dREN) state_nxt = DREAD;
        else if (mif.iREN) state_nxt = IFETCH;
      end
      IFETCH, DREAD, DWRITE: begin
        if ((mif.ramstate == ACCESS) || abort) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mif.ramREN = 1'b0;
    mif.ramWEN = 1'b0;
    mif.ihit   = 1'b0;
    mif.dhit   = 1'b0;
    case (state)
      IFETCH, DREAD: mif.ramREN = 1'b1;
      DWRITE:        mif.ramWEN = 1'b1;
      DONE: begin
        mif.ihit = (kind == IFETCH);
        mif.dhit = (kind == DREAD) || (kind == DWRITE);
      end
      default: ;
    endcase
  end

  // RAM address/data come only from the capture registers so a requester
  // changing its inputs mid-access cannot disturb the RAM.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cap_addr  <= '0;
      cap_store <= '0;
      kind      <= IDLE;
      iload_q   <= '0;
      dload_q   <= '0;
    end else begin
      if ((state == IDLE) && (state_nxt != IDLE)) begin
        cap_addr  <= (mif.dWEN || mif.dREN) ? mif.daddr : mif.iaddr;
        cap_store <= mif.dstore;
        kind      <= state_nxt;
      end
      if ((state == IFETCH) && (state_nxt == DONE)) iload_q <= load_val;
      if ((state == DREAD)  && (state_nxt == DONE)) dload_q <= load_val;
    end
  end

  assign mif.ramaddr  = cap_addr;
  assign mif.ramstore = cap_store;
  assign mif.iload    = iload_q;
  assign mif.dload    = dload_q;

endmodule

// File: tb/tb_memory_control.sv
// Self-checking bench for memory_control: vector table, random requests against a word-array model, directed corners.
// Build with or without MEMCTL_TIMEOUT_EN; timeout expectations follow the macro.
module tb_memory_control;
  import cpu_types_pkg::*;

  localparam int    TB_TO   = 8;
  localparam word_t ERR_VAL = 32'hBAD1BAD1;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  memory_control_if bus();

  memory_control #(
`ifdef MEMCTL_TIMEOUT_EN
    .TIMEOUT_CYCLES(TB_TO),
`endif
    .ERR_WORD(ERR_VAL)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .mif  (bus)
  );

  int    tests = 0, fails = 0, cyc = 0;
  bit    ram_auto, ram_active, both_hit;
  int    lat_left;
  int    lat_q[$];
  word_t ram[16], ref_mem[16];
  word_t exp_iload, exp_dload;

  typedef struct {
    bit        i, dr, dw;
    logic [3:0] ii, di;
    word_t     st;
    int        lat;
    logic [1:0] exp_hit;   // {ihit,dhit}
    int        exp_cyc;
    word_t     exp_val;
    word_t     exp_val2;   // iload of a fetch left pending behind a data request
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: advance to the next negedge, then play the RAM if it is automatic.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (bus.ihit && bus.dhit) both_hit = 1'b1;
    if (ram_auto) begin
      if (bus.ramREN || bus.ramWEN) begin
        if (!ram_active) begin
          ram_active = 1'b1;
          lat_left   = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        end
        if (lat_left == 0) begin
          bus.ramstate = ACCESS;
          bus.ramload  = ram[bus.ramaddr[5:2]];
          if (bus.ramWEN) ram[bus.ramaddr[5:2]] = bus.ramstore;
        end else begin
          bus.ramstate = BUSY;
          lat_left--;
        end
      end else begin
        ram_active   = 1'b0;
        bus.ramstate = FREE;
      end
    end
  endtask

  task automatic wait_hit(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (bus.ihit || bus.dhit) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_req();
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
  endtask

  // Issue a request set and check every resulting hit against the word-array model.
  task automatic serve(input bit i, dr, dw, input logic [3:0] ii, di, input word_t st,
                       input int lat_d, lat_i);
    bit pend_i, pend_d, ok;
    int start;
    pend_i = i;
    pend_d = dr | dw;
    if (pend_d) lat_q.push_back(lat_d);
    if (pend_i) lat_q.push_back(lat_i);
    bus.iREN   = i;
    bus.dREN   = dr;
    bus.dWEN   = dw;
    bus.iaddr  = {26'd0, ii, 2'b00};
    bus.daddr  = {26'd0, di, 2'b00};
    bus.dstore = st;
    start = cyc;
    while (pend_i || pend_d) begin
      wait_hit(40, ok);
      if (!ok) begin
        check("rand_hit_timeout", 32'd0, 32'd1);
        clear_req();
        lat_q.delete();
        return;
      end
      if (pend_d) begin
        check("rand_kind_d", {30'd0, bus.ihit, bus.dhit}, 32'd1);
        check("rand_lat_d", cyc - start, 2 + lat_d);
        if (dw) ref_mem[di] = st;
        else    exp_dload = ref_mem[di];
        check("rand_dload", bus.dload, exp_dload);
        pend_d   = 1'b0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
      end else begin
        check("rand_kind_i", {30'd0, bus.ihit, bus.dhit}, 32'd2);
        check("rand_lat_i", cyc - start, 2 + lat_i);
        exp_iload = ref_mem[ii];
        check("rand_iload", bus.iload, exp_iload);
        pend_i   = 1'b0;
        bus.iREN = 1'b0;
      end
      start = cyc + 1;
    end
    tick();
  endtask

  initial begin
    vec_t vecs[8];
    bit   ok;
    int   start, hits;

    vecs[0] = '{1, 0, 0, 4'd2, 4'd0, 32'h0,        0, 2'b10, 2, 32'hA0000002, 32'h0};
    vecs[1] = '{0, 1, 0, 4'd0, 4'd3, 32'h0,        2, 2'b01, 4, 32'hA0000003, 32'h0};
    vecs[2] = '{0, 0, 1, 4'd0, 4'd4, 32'h12345678, 1, 2'b01, 3, 32'hA0000003, 32'h0};
    vecs[3] = '{0, 1, 0, 4'd0, 4'd4, 32'h0,        0, 2'b01, 2, 32'h12345678, 32'h0};
    vecs[4] = '{1, 1, 0, 4'd1, 4'd5, 32'h0,        0, 2'b01, 2, 32'hA0000005, 32'hA0000001};
    vecs[5] = '{0, 1, 1, 4'd0, 4'd6, 32'hCAFEF00D, 3, 2'b01, 5, 32'hA0000005, 32'h0};
    vecs[6] = '{1, 0, 0, 4'd6, 4'd0, 32'h0,        1, 2'b10, 3, 32'hCAFEF00D, 32'h0};
    vecs[7] = '{1, 0, 1, 4'd7, 4'd7, 32'h0,        0, 2'b01, 2, 32'hA0000005, 32'h0};

    for (int k = 0; k < 16; k++) begin
      ram[k]     = 32'hA0000000 + k;
      ref_mem[k] = ram[k];
    end
    ram_auto     = 1'b1;
    ram_active   = 1'b0;
    both_hit     = 1'b0;
    nRST         = 1'b0;
    clear_req();
    bus.iaddr    = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;

    #1;
    check("rst_ihit",     bus.ihit,     0);
    check("rst_dhit",     bus.dhit,     0);
    check("rst_iload",    bus.iload,    0);
    check("rst_dload",    bus.dload,    0);
    check("rst_ramREN",   bus.ramREN,   0);
    check("rst_ramWEN",   bus.ramWEN,   0);
    check("rst_ramaddr",  bus.ramaddr,  0);
    check("rst_ramstore", bus.ramstore, 0);
    check("rst_memerr",   bus.memerr,   0);
    tick();
    tick();
    nRST = 1'b1;
    tick();

    // Vector table
    for (int v = 0; v < 8; v++) begin
      lat_q.push_back(vecs[v].lat);
      bus.iREN   = vecs[v].i;
      bus.dREN   = vecs[v].dr;
      bus.dWEN   = vecs[v].dw;
      bus.iaddr  = {26'd0, vecs[v].ii, 2'b00};
      bus.daddr  = {26'd0, vecs[v].di, 2'b00};
      bus.dstore = vecs[v].st;
      start = cyc;
      wait_hit(40, ok);
      check($sformatf("vec%0d_hit", v), {30'd0, bus.ihit, bus.dhit}, {30'd0, vecs[v].exp_hit});
      check($sformatf("vec%0d_lat", v), cyc - start, vecs[v].exp_cyc);
      if (vecs[v].exp_hit == 2'b10) begin
        check($sformatf("vec%0d_iload", v), bus.iload, vecs[v].exp_val);
        exp_iload = vecs[v].exp_val;
        bus.iREN  = 1'b0;
      end else begin
        check($sformatf("vec%0d_dload", v), bus.dload, vecs[v].exp_val);
        exp_dload = vecs[v].exp_val;
        if (vecs[v].dw) ref_mem[vecs[v].di] = vecs[v].st;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
      end
      if (bus.iREN) begin
        wait_hit(40, ok);
        check($sformatf("vec%0d_hit2", v), {30'd0, bus.ihit, bus.dhit}, 32'd2);
        check($sformatf("vec%0d_iload2", v), bus.iload, vecs[v].exp_val2);
        exp_iload = vecs[v].exp_val2;
        bus.iREN  = 1'b0;
      end
      tick();
    end

    // Randomised request mixes against the model
    for (int n = 0; n < 40; n++) begin
      logic [2:0] r;
      r = 3'($urandom_range(0, 7));
      if (r == 3'd0) r = 3'd1;
      serve(r[0], r[1], r[2], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Manual RAM for the directed corners
    ram_auto     = 1'b0;
    bus.ramstate = FREE;

    // Fetch with ACCESS on the first cycle
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    tick();
    check("if_ramREN_c1", bus.ramREN, 1);
    check("if_ramaddr_c1", bus.ramaddr, 32'h40);
    check("if_ihit_c1", bus.ihit, 0);
    bus.ramstate = ACCESS; bus.ramload = 32'h8C220004;
    tick();
    check("if_ihit_c2", bus.ihit, 1);
    check("if_iload_c2", bus.iload, 32'h8C220004);
    check("if_ramREN_c2", bus.ramREN, 0);
    bus.iREN = 1'b0; bus.ramstate = FREE; bus.ramload = 32'h0;
    tick();
    check("if_ihit_c3", bus.ihit, 0);
    check("if_iload_hold", bus.iload, 32'h8C220004);
    exp_iload = 32'h8C220004;

    // iaddr changes while the 0x40 fetch is waiting
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    tick();
    bus.ramstate = BUSY; bus.iaddr = 32'h44;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("addr_hold_busy", bus.ramaddr, 32'h40);
    end
    bus.ramstate = ACCESS; bus.ramload = 32'h11112222;
    tick();
    check("addr_hold_done", bus.ramaddr, 32'h40);
    check("addr_hold_ihit", bus.ihit, 1);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    tick();

    // Write beats read, 3 BUSY then ACCESS
    bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
    start = cyc;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("wr_ramWEN", bus.ramWEN, 1);
      check("wr_ramREN", bus.ramREN, 0);
      check("wr_ramaddr", bus.ramaddr, 32'h200);
      check("wr_ramstore", bus.ramstore, 32'hDEADBEEF);
      check("wr_dhit_early", bus.dhit, 0);
      bus.ramstate = (k < 4) ? BUSY : ACCESS;
    end
    tick();
    check("wr_dhit", bus.dhit, 1);
    check("wr_lat", cyc - start, 5);
    check("wr_dload_unchanged", bus.dload, exp_dload);
    bus.dWEN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
    tick();

    // Asynchronous reset in the middle of a waiting read
    bus.dREN = 1'b1; bus.daddr = 32'h100;
    tick();
    bus.ramstate = BUSY;
    tick();
    #2 nRST = 1'b0;
    #1;
    check("arst_ramREN", bus.ramREN, 0);
    check("arst_ramaddr", bus.ramaddr, 0);
    check("arst_iload", bus.iload, 0);
    check("arst_dload", bus.dload, 0);
    check("arst_dhit", bus.dhit, 0);
    bus.dREN = 1'b0;
    tick();
    nRST = 1'b1; bus.ramstate = FREE;
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.ihit || bus.dhit || bus.ramREN) hits++;
    end
    check("arst_no_activity", hits, 0);
    exp_iload = 32'h0;
    exp_dload = 32'h0;

    // RAM never grants
`ifdef MEMCTL_TIMEOUT_EN
    bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = BUSY;
    start = cyc;
    wait_hit(40, ok);
    check("to_hit", {31'd0, ok & bus.dhit}, 1);
    check("to_lat", cyc - start, TB_TO + 2);
    check("to_dload", bus.dload, ERR_VAL);
    check("to_memerr", bus.memerr, 1);
    bus.dREN = 1'b0; bus.ramstate = FREE;
    for (int k = 0; k < 3; k++) tick();
    check("to_memerr_sticky", bus.memerr, 1);
    check("to_dload_hold", bus.dload, ERR_VAL);
    bus.iREN = 1'b1; bus.iaddr = 32'h8; bus.ramstate = ERROR;
    start = cyc;
    wait_hit(40, ok);
    check("err_ihit", {31'd0, ok & bus.ihit}, 1);
    check("err_lat", cyc - start, 2);
    check("err_iload", bus.iload, ERR_VAL);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    tick();
`else
    bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = ERROR;
    hits = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (k == 15) bus.ramstate = BUSY;
      if (bus.ihit || bus.dhit) hits++;
    end
    check("nto_no_hit", hits, 0);
    check("nto_memerr", bus.memerr, 0);
    check("nto_ramREN", bus.ramREN, 1);
    bus.dREN = 1'b0; bus.ramstate = ACCESS; bus.ramload = 32'h55AA55AA;
    tick();
    check("nto_dhit", bus.dhit, 1);
    check("nto_dload", bus.dload, 32'h55AA55AA);
    bus.ramstate = FREE;
    tick();
`endif

    check("hit_exclusive", {31'd0, both_hit}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
